// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit framer. Pops words from a FIFO and shifts them
//               out LSB first with start/parity/stop bits, paced by a bit tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    output logic              fifo_rd_en_o,
    input  logic              break_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_serializer: DATA_W must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic [3:0] c_LAST_BIT  = 4'(DATA_W - 1);
    localparam logic       c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       c_PAR_EN    = 1'(PARITY_EN);
    localparam logic       c_PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [3:0]          r_bit_cnt;
    logic                r_stop_cnt;
    logic                r_parity;
    logic                r_load;
    logic                r_break;
    logic                r_run;
    logic                w_rd_en;
    logic                w_done;
    logic                w_more;

    // r_run keeps the FIFO untouched while reset is held and until a clock
    // has passed after its release.
    assign w_more = ~fifo_empty_i & ~break_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bit_tick_i && w_more && r_run) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_tick_i) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_tick_i && r_bit_cnt == c_LAST_BIT) begin
                    w_state_nxt = c_PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_tick_i) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_tick_i && r_stop_cnt == c_LAST_STOP) begin
                    w_done = 1'b1;
                    if (w_more) begin
                        w_rd_en     = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_load     <= 1'b0;
            r_break    <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_load  <= w_rd_en;
            r_break <= break_i;
            r_run   <= 1'b1;
            // FIFO data is valid the cycle after the pop strobe
            if (r_load) begin
                r_shift  <= fifo_rd_data_i;
                r_parity <= (^fifo_rd_data_i) ^ c_PAR_ODD;
            end else if (r_state == S_DATA && bit_tick_i) begin
                r_shift <= r_shift >> 1;
            end
            if (r_state == S_START && bit_tick_i) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && bit_tick_i) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_state_nxt == S_STOP && r_state != S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (r_state == S_STOP && bit_tick_i) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (r_state)
            S_IDLE:   tx_o = ~r_break;
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = r_shift[0];
            S_PARITY: tx_o = r_parity;
            S_STOP:   tx_o = 1'b1;
            default:  tx_o = 1'b1;
        endcase
    end

    assign busy_o       = (r_state != S_IDLE);
    assign fifo_rd_en_o = w_rd_en;
    assign frame_done_o = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for three framer configurations sharing
//               one FIFO model and one bit-tick source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       brk;
    logic [7:0] fdata;
    logic [2:0] act;
    logic [2:0] empty_w;
    logic [2:0] tx_w, rd_w, busy_w, done_w;

    logic [7:0] q[$];
    logic       exp_q[$];
    logic       pend;
    int         rd_cnt[3];
    int         done_cnt[3];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // k=0: defaults; k=1: 7 bits even parity 2 stops; k=2: same with odd parity
    uart_tx_serializer u_dut0 (
        .clk(clk), .rst_n(rst_n), .bit_tick_i(tick), .fifo_empty_i(empty_w[0]),
        .fifo_rd_data_i(fdata), .fifo_rd_en_o(rd_w[0]), .break_i(brk),
        .tx_o(tx_w[0]), .busy_o(busy_w[0]), .frame_done_o(done_w[0]));

    uart_tx_serializer #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bit_tick_i(tick), .fifo_empty_i(empty_w[1]),
        .fifo_rd_data_i(fdata[6:0]), .fifo_rd_en_o(rd_w[1]), .break_i(brk),
        .tx_o(tx_w[1]), .busy_o(busy_w[1]), .frame_done_o(done_w[1]));

    uart_tx_serializer #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bit_tick_i(tick), .fifo_empty_i(empty_w[2]),
        .fifo_rd_data_i(fdata[6:0]), .fifo_rd_en_o(rd_w[2]), .break_i(brk),
        .tx_o(tx_w[2]), .busy_o(busy_w[2]), .frame_done_o(done_w[2]));

    task automatic fifo_sync();
        empty_w = ~act | ((q.size() == 0) ? 3'b111 : 3'b000);
    endtask

    // FIFO model: word appears the cycle after a pop, random garbage otherwise
    initial begin
        fdata = '0;
        pend  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pend && q.size() > 0) begin
                fdata = q.pop_front();
                fifo_sync();
            end else begin
                fdata = 8'($urandom);
            end
            pend = 1'b0;
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rd_cnt[k]   = 0;
            done_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rd_w[k] === 1'b1)   rd_cnt[k]++;
                if (done_w[k] === 1'b1) done_cnt[k]++;
            end
            if (|(rd_w & act)) pend = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, got, want);
        end
    endtask

    // Reference: line levels per bit period derived from the frame format
    function automatic void frame_bits(input int k, input logic [7:0] d);
        int   dw;
        logic p;
        dw = (k == 0) ? 8 : 7;
        p  = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (k != 0) exp_q.push_back(p ^ (k == 2));
        for (int i = 0; i < ((k == 0) ? 1 : 2); i++) exp_q.push_back(1'b1);
    endfunction

    // One 16-cycle bit period; tx/busy sampled mid-period, tick on the last cycle
    task automatic period(input int k, output logic s_tx, output logic s_busy);
        repeat (7) @(posedge clk);
        @(negedge clk);
        s_tx   = tx_w[k];
        s_busy = busy_w[k];
        repeat (8) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic run_stream(input int k, input string tag, input int nw);
        int   rd0, dn0, n;
        logic s_tx, s_busy;
        rd0 = rd_cnt[k];
        dn0 = done_cnt[k];
        n   = exp_q.size();
        period(k, s_tx, s_busy);
        chk({tag, " idle-pre tx/busy"}, {s_tx, s_busy}, 2'b10);
        for (int i = 0; i < n; i++) begin
            period(k, s_tx, s_busy);
            chk($sformatf("%s bit%0d tx/busy", tag, i), {s_tx, s_busy}, {exp_q[i], 1'b1});
        end
        period(k, s_tx, s_busy);
        chk({tag, " idle-post tx/busy"}, {s_tx, s_busy}, 2'b10);
        chk({tag, " rd_en pulses"}, rd_cnt[k] - rd0, nw);
        chk({tag, " frame_done pulses"}, done_cnt[k] - dn0, nw);
        exp_q.delete();
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        string      bits;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int   rd0, dn0, nw, k;
        logic s_tx, s_busy;
        logic [7:0] d;

        tbl[0] = '{0, 8'hA5, "0101001011"};
        tbl[1] = '{1, 8'h41, "01000001011"};
        tbl[2] = '{2, 8'h41, "01000001111"};
        tbl[3] = '{0, 8'h00, "0000000001"};
        tbl[4] = '{1, 8'h7F, "01111111111"};
        tbl[5] = '{2, 8'h7F, "01111111011"};
        tbl[6] = '{0, 8'h3C, "0001111001"};

        rst_n = 1'b0;
        tick  = 1'b0;
        brk   = 1'b0;
        act   = 3'b000;
        fifo_sync();
        repeat (3) @(posedge clk);
        #1;
        q.push_back(8'h55);
        act = 3'b111;
        fifo_sync();
        tick = 1'b1;
        #1;
        chk("reset rd_en", rd_w, 3'b000);
        chk("reset tx", tx_w, 3'b111);
        chk("reset busy", busy_w, 3'b000);
        chk("reset frame_done", done_w, 3'b000);
        @(posedge clk);
        #1;
        tick = 1'b0;
        q.delete();
        act = 3'b000;
        fifo_sync();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Spec vectors and extra single frames
        for (int i = 0; i < 7; i++) begin
            act = 3'(1 << tbl[i].k);
            q.push_back(tbl[i].d);
            fifo_sync();
            for (int j = 0; j < tbl[i].bits.len(); j++) exp_q.push_back(tbl[i].bits[j] == "1");
            run_stream(tbl[i].k, $sformatf("vec%0d", i), 1);
        end

        // Back-to-back 0x00 then 0xFF
        act = 3'b001;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        fifo_sync();
        frame_bits(0, 8'h00);
        frame_bits(0, 8'hFF);
        run_stream(0, "b2b", 2);

        // Empty FIFO: ticks change nothing
        rd0 = rd_cnt[0];
        for (int i = 0; i < 10; i++) begin
            period(0, s_tx, s_busy);
            chk($sformatf("empty p%0d tx/busy", i), {s_tx, s_busy}, 2'b10);
        end
        chk("empty rd_en pulses", rd_cnt[0] - rd0, 0);

        // Break in IDLE with data waiting
        brk = 1'b1;
        q.push_back(8'h5A);
        fifo_sync();
        for (int i = 0; i < 3; i++) begin
            period(0, s_tx, s_busy);
            chk($sformatf("break p%0d tx/busy", i), {s_tx, s_busy}, 2'b00);
        end
        chk("break rd_en pulses", rd_cnt[0] - rd0, 0);
        brk = 1'b0;
        @(negedge clk);
        chk("break release same cycle tx", tx_w[0], 1'b0);
        @(negedge clk);
        chk("break release next cycle tx", tx_w[0], 1'b1);
        @(posedge clk);
        #1;
        frame_bits(0, 8'h5A);
        run_stream(0, "post-break", 1);

        // Reset during data bit 3 of an all-zero word
        rd0 = rd_cnt[0];
        dn0 = done_cnt[0];
        q.push_back(8'h00);
        fifo_sync();
        for (int i = 0; i < 5; i++) period(0, s_tx, s_busy);
        chk("pre-abort bit2 tx/busy", {s_tx, s_busy}, 2'b01);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort tx", tx_w[0], 1'b1);
        chk("abort busy", busy_w[0], 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort rd_en pulses", rd_cnt[0] - rd0, 1);
        chk("abort frame_done pulses", done_cnt[0] - dn0, 0);
        q.push_back(8'hC3);
        fifo_sync();
        frame_bits(0, 8'hC3);
        run_stream(0, "post-abort", 1);

        // Random bursts against the reference model
        for (int r = 0; r < 9; r++) begin
            k   = r % 3;
            nw  = $urandom_range(1, 3);
            act = 3'(1 << k);
            for (int w = 0; w < nw; w++) begin
                d = 8'($urandom);
                q.push_back(d);
                frame_bits(k, d);
            end
            fifo_sync();
            run_stream(k, $sformatf("rnd%0d", r), nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
